// File: rtl/spgd_update_if.sv
// Metric front-end handshake: level request out, sample + valid back.
// master = spgd_update (requester), slave = metric/ADC front end.
`timescale 1ns/1ps
interface spgd_update_if #(
   parameter int FP_WIDTH = 64
);
   logic                       meas_req;
   logic                       meas_valid;
   logic signed [FP_WIDTH-1:0] meas_J;

   modport master (output meas_req, input meas_valid, input meas_J);
   modport slave  (input meas_req, output meas_valid, output meas_J);
endinterface

// File: rtl/spgd_update.sv
// Two-channel SPGD iteration: apply U+p then U-p, capture J+/J-, update U += GAIN*(J+ - J-)*p.
// Optional macro SPGD_CLAMP_EN clamps the drive and U into [U_MIN, U_MAX].
`timescale 1ns/1ps
module spgd_update #(
   parameter int FP_WIDTH      = 64,
   parameter int FRAC_BITS     = 48,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic signed [FP_WIDTH-1:0] PERT_A,
   input  logic signed [FP_WIDTH-1:0] PERT_B,
   input  logic signed [FP_WIDTH-1:0] GAIN,
   input  logic signed [FP_WIDTH-1:0] U_MIN,
   input  logic signed [FP_WIDTH-1:0] U_MAX,
   spgd_update_if.master              meas,
   output logic signed [FP_WIDTH-1:0] DRIVE_A,
   output logic signed [FP_WIDTH-1:0] DRIVE_B,
   output logic signed [FP_WIDTH-1:0] U_A,
   output logic signed [FP_WIDTH-1:0] U_B,
   output logic                       busy,
   output logic                       done,
   output logic [31:0]                iter_cnt
);

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic signed [FP_WIDTH-1:0] MAX_V = {1'b0, {(FP_WIDTH-1){1'b1}}};
   localparam logic signed [FP_WIDTH-1:0] MIN_V = {1'b1, {(FP_WIDTH-1){1'b0}}};

   typedef enum logic [3:0] {
      S_IDLE, S_LATCH, S_SET_POS, S_WAIT_POS, S_SET_NEG,
      S_WAIT_NEG, S_MUL1, S_MUL2, S_UPDATE, S_DONE
   } state_t;

   state_t                     state, state_next;
   logic [CNT_W-1:0]           cnt;
   logic signed [FP_WIDTH-1:0] p_a, p_b, jp, jn, k, d_a, d_b;
   logic signed [FP_WIDTH-1:0] u_new_a, u_new_b;

   function automatic logic signed [FP_WIDTH-1:0] sat_add(input logic signed [FP_WIDTH-1:0] a,
                                                          input logic signed [FP_WIDTH-1:0] b);
      logic signed [FP_WIDTH:0] s;
      s = {a[FP_WIDTH-1], a} + {b[FP_WIDTH-1], b};
      if (s[FP_WIDTH] != s[FP_WIDTH-1]) return s[FP_WIDTH] ? MIN_V : MAX_V;
      return s[FP_WIDTH-1:0];
   endfunction

   function automatic logic signed [FP_WIDTH-1:0] sat_sub(input logic signed [FP_WIDTH-1:0] a,
                                                          input logic signed [FP_WIDTH-1:0] b);
      logic signed [FP_WIDTH:0] s;
      s = {a[FP_WIDTH-1], a} - {b[FP_WIDTH-1], b};
      if (s[FP_WIDTH] != s[FP_WIDTH-1]) return s[FP_WIDTH] ? MIN_V : MAX_V;
      return s[FP_WIDTH-1:0];
   endfunction

   // Full-width product; the bit slice is an arithmetic shift, i.e. truncation toward -inf.
   function automatic logic signed [FP_WIDTH-1:0] mul_trunc(input logic signed [FP_WIDTH-1:0] a,
                                                            input logic signed [FP_WIDTH-1:0] b);
      logic signed [2*FP_WIDTH-1:0] prod;
      prod = $signed({{FP_WIDTH{a[FP_WIDTH-1]}}, a}) * $signed({{FP_WIDTH{b[FP_WIDTH-1]}}, b});
      return prod[FRAC_BITS+FP_WIDTH-1:FRAC_BITS];
   endfunction

`ifdef SPGD_CLAMP_EN
   // An inverted window (U_MIN > U_MAX) pins everything to U_MIN.
   function automatic logic signed [FP_WIDTH-1:0] limit(input logic signed [FP_WIDTH-1:0] x);
      if (U_MIN > U_MAX) return U_MIN;
      if (x < U_MIN)     return U_MIN;
      if (x > U_MAX)     return U_MAX;
      return x;
   endfunction
`else
   function automatic logic signed [FP_WIDTH-1:0] limit(input logic signed [FP_WIDTH-1:0] x);
      return x;
   endfunction

   logic unused_bounds;
   assign unused_bounds = ^{U_MIN, U_MAX};
`endif

   assign u_new_a = limit(sat_add(U_A, d_a));
   assign u_new_b = limit(sat_add(U_B, d_b));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next    = state;
      busy          = 1'b1;
      done          = 1'b0;
      meas.meas_req = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_next = S_LATCH;
         end
         S_LATCH:    state_next = S_SET_POS;
         S_SET_POS:  if (cnt == '0) state_next = S_WAIT_POS;
         S_WAIT_POS: begin
            meas.meas_req = 1'b1;
            if (meas.meas_valid) state_next = S_SET_NEG;
         end
         S_SET_NEG:  if (cnt == '0) state_next = S_WAIT_NEG;
         S_WAIT_NEG: begin
            meas.meas_req = 1'b1;
            if (meas.meas_valid) state_next = S_MUL1;
         end
         S_MUL1:     state_next = S_MUL2;
         S_MUL2:     state_next = S_UPDATE;
         S_UPDATE:   state_next = S_DONE;
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default:    state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         p_a      <= '0;
         p_b      <= '0;
         jp       <= '0;
         jn       <= '0;
         k        <= '0;
         d_a      <= '0;
         d_b      <= '0;
         U_A      <= '0;
         U_B      <= '0;
         DRIVE_A  <= '0;
         DRIVE_B  <= '0;
         iter_cnt <= '0;
      end else begin
         case (state)
            // Perturbation is frozen here; the positive drive is built from the same inputs.
            S_LATCH: begin
               p_a     <= PERT_A;
               p_b     <= PERT_B;
               DRIVE_A <= limit(sat_add(U_A, PERT_A));
               DRIVE_B <= limit(sat_add(U_B, PERT_B));
               cnt     <= SET_LAST;
            end
            S_SET_POS, S_SET_NEG: if (cnt != '0) cnt <= cnt - 1'b1;
            S_WAIT_POS: if (meas.meas_valid) begin
               jp      <= meas.meas_J;
               DRIVE_A <= limit(sat_sub(U_A, p_a));
               DRIVE_B <= limit(sat_sub(U_B, p_b));
               cnt     <= SET_LAST;
            end
            S_WAIT_NEG: if (meas.meas_valid) jn <= meas.meas_J;
            S_MUL1: k <= mul_trunc(GAIN, sat_sub(jp, jn));
            S_MUL2: begin
               d_a <= mul_trunc(k, p_a);
               d_b <= mul_trunc(k, p_b);
            end
            S_UPDATE: begin
               U_A      <= u_new_a;
               U_B      <= u_new_b;
               DRIVE_A  <= u_new_a;
               DRIVE_B  <= u_new_b;
               iter_cnt <= iter_cnt + 32'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/spgd_update.md
Name: spgd_update

Overview:
- Consumer end of the perturbation path. Latches one perturbation pair (PERT_A, PERT_B) from the PRNG and applies it to the actuators as u+p, then u−p.
- Handshakes with the metric front end to capture J+ and J−, then performs the two-channel SPGD control update u ← u + GAIN·(J+ − J−)·p.
- Sits between the PRNG, the metric/ADC interface and the actuator drivers.
- All data is signed Q16.48 two's complement, the same format the PRNG produces.

Parameters:
- FP_WIDTH, 64, data width; fixed-point format is Q(FP_WIDTH−FRAC_BITS).FRAC_BITS.
- FRAC_BITS, 48, fractional bits of every data operand.
- SETTLE_CYCLES, 4, cycles drive is held stable before a measurement request (≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin one iteration; sampled only in IDLE.
- PERT_A  in  FP_WIDTH  perturbation, channel A (from PRNG).
- PERT_B  in  FP_WIDTH  perturbation, channel B (from PRNG).
- GAIN  in  FP_WIDTH  signed update gain; negative value = minimise J.
- U_MIN  in  FP_WIDTH  lower clamp bound (used only with SPGD_CLAMP_EN).
- U_MAX  in  FP_WIDTH  upper clamp bound (used only with SPGD_CLAMP_EN).
- meas_req  out  1  level request for a metric sample.
- meas_valid  in  1  metric sample valid.
- meas_J  in  FP_WIDTH  metric value.
- DRIVE_A  out  FP_WIDTH  actuator drive, channel A.
- DRIVE_B  out  FP_WIDTH  actuator drive, channel B.
- U_A  out  FP_WIDTH  control state, channel A.
- U_B  out  FP_WIDTH  control state, channel B.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when an iteration completes.
- iter_cnt  out  32  completed-iteration counter, wraps at 2^32.

Behaviour:
- Reset (rst=0, async): state IDLE; U_A, U_B, DRIVE_A, DRIVE_B = 0; meas_req, busy, done = 0; iter_cnt = 0; all internal registers cleared. A reset in mid-iteration abandons the iteration; U is not updated.
- States and transitions:
  - IDLE → LATCH on start=1.
  - LATCH: register pA=PERT_A, pB=PERT_B. PRNG changes afterwards are ignored.
  - SET_POS: DRIVE = U+p (saturating); wait SETTLE_CYCLES cycles.
  - WAIT_POS: meas_req=1; on meas_valid=1 capture Jp.
  - SET_NEG: DRIVE = U−p (saturating); wait SETTLE_CYCLES cycles.
  - WAIT_NEG: meas_req=1; on meas_valid=1 capture Jn.
  - MUL1: dJ = Jp−Jn (saturating); k = (GAIN·dJ)[FRAC_BITS+FP_WIDTH−1:FRAC_BITS], where the product is a full 2·FP_WIDTH signed product.
  - MUL2: dA = (k·pA) truncated the same way; dB = (k·pB) likewise.
  - UPDATE: U ← sat(U+d); DRIVE ← new U; iter_cnt+1.
  - DONE: done=1 for one cycle → IDLE.
- Truncation toward −∞ (arithmetic shift). Saturation limits are the signed FP_WIDTH min/max.
- Latency with meas_valid returned on the first cycle of each WAIT: start to done = 2·SETTLE_CYCLES + 8 cycles (10 + 2·SETTLE_CYCLES − 2).
- meas_req is a level, high throughout WAIT_*. It drops the cycle after meas_valid is accepted. meas_valid outside WAIT_* is ignored.
- start while busy is ignored (no queuing). start in the DONE cycle is ignored; start is accepted in the following IDLE cycle.
- In IDLE, DRIVE = U.

Optional Feature:
- Macro: SPGD_CLAMP_EN.
- Defined: after saturation, UPDATE clamps U into [U_MIN, U_MAX]. If U_MIN > U_MAX, U = U_MIN. The drive is clamped to the same bounds in SET_POS and SET_NEG.
- Undefined: U_MIN and U_MAX are ignored; only signed-range saturation applies.

Test Plan:
- Basic update: U=0, PERT_A=0x0000_8000_0000_0000 (+0.5), PERT_B=0xFFFF_C000_0000_0000 (−0.25), GAIN=0x0001_0000_0000_0000 (1.0), Jp=2.0, Jn=1.0 → DRIVE_A=+0.5 in POS, −0.5 in NEG; U_A=+0.5, U_B=−0.25; done pulses once; iter_cnt=1.
- Latency: SETTLE_CYCLES=4, meas_valid on the first WAIT cycle → done exactly 16 cycles after start. PERT changed after LATCH → result unchanged.
- Saturation: U_A=0x7FFF_0000_0000_0000, dA=+2.0 → U_A=0x7FFF_FFFF_FFFF_FFFF. Mirror case at the negative minimum.
- Handshake: meas_valid delayed 20 cycles → meas_req held high, state frozen. Spurious meas_valid pulses in IDLE and SET_* → ignored. start pulsed while busy → no second iteration.
- Reset mid-WAIT_NEG: assert rst=0 → all outputs 0 asynchronously; after release, idle, with a subsequent start behaving as the first iteration.
- SPGD_CLAMP_EN defined: U_MAX=0.25, basic-update stimulus → U_A=0.25 and DRIVE_A clamped to 0.25 in SET_POS. Undefined: same stimulus → U_A=0.5.
